// File: rtl/camellia_pkg.sv
// Shared Camellia datapath constants, the FL subkey pair type and the word rotate helper.
package camellia_pkg;

  localparam int BLOCK_W = 128;
  localparam int HALF_W  = 64;
  localparam int WORD_W  = 32;

  typedef struct packed {
    logic [WORD_W-1:0] kl;
    logic [WORD_W-1:0] kr;
  } subkey_t;

  // Rotating a doubled copy keeps the wrapped bits in the upper word.
  function automatic logic [WORD_W-1:0] rol32(input logic [WORD_W-1:0] x, input logic [4:0] n);
    logic [2*WORD_W-1:0] dbl;
    dbl = {x, x} << n;
    return dbl[2*WORD_W-1:WORD_W];
  endfunction

endpackage

// File: rtl/camellia_fl_core.sv
// Combinational FL on the upper half and FL^-1 on the lower half of a 128-bit block.
module camellia_fl_core
  import camellia_pkg::*;
(
  input  logic [BLOCK_W-1:0] i_data,
  input  logic [HALF_W-1:0]  i_ke1,
  input  logic [HALF_W-1:0]  i_ke2,
  output logic [BLOCK_W-1:0] o_data
);

  subkey_t           k1;
  subkey_t           k2;
  logic [WORD_W-1:0] dl_l, dl_r, dr_l, dr_r;
  logic [WORD_W-1:0] fl_l, fl_r, inv_l, inv_r;

  assign k1 = subkey_t'(i_ke1);
  assign k2 = subkey_t'(i_ke2);
  assign {dl_l, dl_r, dr_l, dr_r} = i_data;

  // FL updates the right word first; FL^-1 undoes the two steps in reverse order.
  assign fl_r  = dl_r ^ rol32(dl_l & k1.kl, 5'd1);
  assign fl_l  = dl_l ^ (fl_r | k1.kr);
  assign inv_l = dr_l ^ (dr_r | k2.kr);
  assign inv_r = dr_r ^ rol32(inv_l & k2.kl, 5'd1);

  assign o_data = {fl_l, fl_r, inv_l, inv_r};

endmodule

// File: rtl/camellia_fl_layer_pipe.sv
// Camellia FL layer followed by a STAGES-deep valid/ready pipeline with bubble collapse.
// Stage 0 captures the FL result (or the raw block on bypass); later stages only delay.
module camellia_fl_layer_pipe
  import camellia_pkg::*;
#(
  parameter int STAGES    = 1,
  parameter int TAG_W     = 4,
  parameter int BYPASS_EN = 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_flush,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [BLOCK_W-1:0] i_data,
  input  logic [HALF_W-1:0]  i_ke1,
  input  logic [HALF_W-1:0]  i_ke2,
  input  logic               i_bypass,
  input  logic [TAG_W-1:0]   i_tag,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [BLOCK_W-1:0] o_data,
  output logic [TAG_W-1:0]   o_tag
);

  localparam logic BYP_OK = (BYPASS_EN != 0);

  logic [BLOCK_W-1:0] fl_data;
  logic [BLOCK_W-1:0] stage0_in;
  logic [STAGES-1:0]  vld_q;
  logic [STAGES-1:0]  vld_d;
  logic [STAGES-1:0]  rdy;
  logic [STAGES-1:0]  up_vld;
  logic [STAGES-1:0]  load;
  logic [BLOCK_W-1:0] data_q [STAGES];
  logic [TAG_W-1:0]   tag_q  [STAGES];

  camellia_fl_core u_core (
    .i_data (i_data),
    .i_ke1  (i_ke1),
    .i_ke2  (i_ke2),
    .o_data (fl_data)
  );

  assign stage0_in = (BYP_OK && i_bypass) ? i_data : fl_data;
  assign o_ready   = rdy[0] & ~i_flush;

  // A stage can take a beat when it is empty or every stage after it can advance.
  always_comb begin
    logic chain;
    chain = i_ready;
    rdy   = '0;
    for (int s = STAGES - 1; s >= 0; s--) begin
      chain  = ~vld_q[s] | chain;
      rdy[s] = chain;
    end
  end

  always_comb begin
    up_vld    = vld_q << 1;
    up_vld[0] = i_valid;
    load      = up_vld & rdy;
    load[0]   = i_valid & o_ready;
    if (i_flush) begin
      vld_d = '0;
    end else begin
      vld_d = (up_vld & rdy) | (vld_q & ~rdy);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_q <= '0;
      for (int s = 0; s < STAGES; s++) begin
        data_q[s] <= '0;
        tag_q[s]  <= '0;
      end
    end else begin
      vld_q <= vld_d;
      if (load[0]) begin
        data_q[0] <= stage0_in;
        tag_q[0]  <= i_tag;
      end
      for (int s = 1; s < STAGES; s++) begin
        if (load[s]) begin
          data_q[s] <= data_q[s-1];
          tag_q[s]  <= tag_q[s-1];
        end
      end
    end
  end

  assign o_valid = vld_q[STAGES-1];
  assign o_data  = data_q[STAGES-1];
  assign o_tag   = tag_q[STAGES-1];

endmodule

// File: tb/tb_camellia_fl_layer_pipe.sv
// Scoreboard bench: four pipeline configurations share one stimulus stream and are checked
// against an FL / FL^-1 reference model kept in the bench.
module tb_camellia_fl_layer_pipe;

  localparam int NI = 4;
  localparam int TW = 4;

  typedef struct {
    logic [127:0]  exp_d;
    logic [127:0]  orig;
    logic [63:0]   k1;
    logic [63:0]   k2;
    logic [TW-1:0] tag;
    logic          byp;
    int            acc;
  } sb_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          flush = 1'b0;
  logic          drv_valid = 1'b0;
  logic          vin;
  logic          i_ready = 1'b1;
  logic [127:0]  data = '0;
  logic [63:0]   ke1 = '0;
  logic [63:0]   ke2 = '0;
  logic          bypass = 1'b0;
  logic [TW-1:0] tag = '0;
  logic [NI-1:0] ordy;
  logic [NI-1:0] ov;
  logic [127:0]  od [NI];
  logic [TW-1:0] ot [NI];

  int  n_cmp = 0;
  int  n_err = 0;
  logic end_req = 1'b0;
  logic end_ack = 1'b0;

  always #5 clk = ~clk;

  // During a flush the beat is presented regardless of readiness, to prove it is refused.
  assign vin = drv_valid & (flush | (&ordy));

  for (genvar g = 0; g < NI; g++) begin : g_dut
    camellia_fl_layer_pipe #(
      .STAGES    ((g == 0) ? 3 : (g == 1) ? 1 : (g == 2) ? 4 : 2),
      .TAG_W     (TW),
      .BYPASS_EN ((g == 1) ? 0 : 1)
    ) u_dut (
      .i_clk    (clk),
      .i_rst_n  (rst_n),
      .i_flush  (flush),
      .i_valid  (vin),
      .o_ready  (ordy[g]),
      .i_data   (data),
      .i_ke1    (ke1),
      .i_ke2    (ke2),
      .i_bypass (bypass),
      .i_tag    (tag),
      .o_valid  (ov[g]),
      .i_ready  (i_ready),
      .o_data   (od[g]),
      .o_tag    (ot[g])
    );
  end

  function automatic int st_of(input int i);
    case (i)
      0:       return 3;
      1:       return 1;
      2:       return 4;
      default: return 2;
    endcase
  endfunction

  function automatic logic be_of(input int i);
    return (i != 1);
  endfunction

  // Reference model: plain-arithmetic FL and FL^-1 on 64-bit halves.
  function automatic logic [31:0] rotl1(input logic [31:0] w);
    return (w << 1) | (w >> 31);
  endfunction

  function automatic logic [63:0] ref_fl(input logic [63:0] x, input logic [63:0] k);
    logic [31:0] yl, yr;
    yr = x[31:0] ^ rotl1(x[63:32] & k[63:32]);
    yl = x[63:32] ^ (yr | k[31:0]);
    return {yl, yr};
  endfunction

  function automatic logic [63:0] ref_flinv(input logic [63:0] y, input logic [63:0] k);
    logic [31:0] xl, xr;
    xl = y[63:32] ^ (y[31:0] | k[31:0]);
    xr = y[31:0] ^ rotl1(xl & k[63:32]);
    return {xl, xr};
  endfunction

  task automatic chk(input string name, input int inst, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s inst%0d (stages=%0d): got %h expected %h", name, inst, st_of(inst), act, exp);
    end
  endtask

  // Monitor / scoreboard: pushes on accepted beats, pops and compares on output transfers.
  sb_t          sbq [NI][$];
  logic         prev_stall [NI];
  logic [127:0] prev_d [NI];
  logic [TW-1:0] prev_t [NI];
  int           ncyc = 0;
  int           last_low = 0;
  int           wait_cyc = 0;

  initial begin : monitor
    sb_t  e;
    logic acc;
    logic pop;
    int   lat;
    for (int i = 0; i < NI; i++) prev_stall[i] = 1'b0;
    forever begin
      @(negedge clk);
      ncyc++;
      if (!rst_n) begin
        for (int i = 0; i < NI; i++) begin
          sbq[i].delete();
          prev_stall[i] = 1'b0;
          chk("reset_o_valid", i, ov[i], 128'd0);
          chk("reset_o_data", i, od[i], 128'd0);
          chk("reset_o_tag", i, ot[i], 128'd0);
        end
        wait_cyc = 0;
      end else begin
        for (int i = 0; i < NI; i++) begin
          acc = vin & ordy[i];
          pop = ov[i] & i_ready;
          chk("o_ready", i, ordy[i], !flush && ((sbq[i].size() < st_of(i)) || i_ready));
          if (prev_stall[i]) begin
            chk("hold_valid", i, ov[i], 128'd1);
            chk("hold_data", i, od[i], prev_d[i]);
            chk("hold_tag", i, ot[i], prev_t[i]);
          end
          if (sbq[i].size() == 0) begin
            chk("spurious_o_valid", i, ov[i], 128'd0);
          end else if (pop) begin
            e   = sbq[i].pop_front();
            lat = ncyc - e.acc;
            chk("o_data", i, od[i], e.exp_d);
            chk("o_tag", i, ot[i], e.tag);
            chk("latency_min", i, (lat >= st_of(i)), 128'd1);
            if (last_low <= e.acc) chk("latency_exact", i, lat, st_of(i));
            if (!(e.byp && be_of(i))) begin
              chk("inverse_upper", i, ref_flinv(od[i][127:64], e.k1), e.orig[127:64]);
              chk("inverse_lower", i, ref_fl(od[i][63:0], e.k2), e.orig[63:0]);
            end
          end
          if (flush) begin
            sbq[i].delete();
          end else if (acc) begin
            e.orig  = data;
            e.k1    = ke1;
            e.k2    = ke2;
            e.tag   = tag;
            e.byp   = bypass;
            e.acc   = ncyc;
            e.exp_d = (bypass && be_of(i)) ? data : {ref_fl(data[127:64], ke1), ref_flinv(data[63:0], ke2)};
            sbq[i].push_back(e);
          end
          prev_stall[i] = ov[i] & ~i_ready & ~flush;
          prev_d[i]     = od[i];
          prev_t[i]     = ot[i];
        end
        if (!i_ready) last_low = ncyc;
        if (drv_valid && !(vin && (&ordy) && !flush)) wait_cyc++;
        else wait_cyc = 0;
        if (drv_valid) chk("accept_wait_bound", 0, (wait_cyc > 200), 128'd0);
      end
      if (end_req && !end_ack) begin
        for (int i = 0; i < NI; i++) chk("drain_empty", i, sbq[i].size(), 128'd0);
        end_ack = 1'b1;
      end
    end
  end

  // Stimulus side
  int mode = 0;  // 0: ready high, 1: random ready, 2: 1-0-0-1 pattern, 3: ready low
  int dcyc = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ready();
    dcyc++;
    case (mode)
      0:       i_ready = 1'b1;
      1:       i_ready = ($urandom_range(0, 99) < 70);
      2:       i_ready = ((dcyc % 4) == 0) || ((dcyc % 4) == 3);
      default: i_ready = 1'b0;
    endcase
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      set_ready();
      step();
    end
  endtask

  task automatic send(input logic [127:0] d, input logic [63:0] k1, input logic [63:0] k2,
                      input logic b, input logic [TW-1:0] t);
    bit took;
    int w;
    data = d; ke1 = k1; ke2 = k2; bypass = b; tag = t;
    drv_valid = 1'b1;
    took = 1'b0;
    w = 0;
    while (!took && w < 300) begin
      set_ready();
      @(negedge clk);
      took = vin && (&ordy) && !flush;
      w++;
      step();
    end
    drv_valid = 1'b0;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : driver
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    mode = 0;
    idle(2);

    send(128'd0, {32'h12345678, 32'hA5A5A5A5}, {32'hFFFFFFFF, 32'h00000000}, 1'b0, 4'h1);
    idle(5);
    send({32'h80000000, 32'h00000000, 32'h80000001, 32'h00000001},
         {32'hFFFFFFFF, 32'h00000000}, {32'hFFFFFFFF, 32'h00000000}, 1'b0, 4'h2);
    idle(5);
    send(128'h0123456789ABCDEF0123456789ABCDEF, rnd64(), rnd64(), 1'b1, 4'h9);
    idle(5);

    mode = 2;
    for (int t = 0; t < 8; t++) send(rnd128(), rnd64(), rnd64(), 1'b0, t[TW-1:0]);
    idle(24);

    mode = 0;
    send(rnd128(), rnd64(), rnd64(), 1'b0, 4'hA);
    send(rnd128(), rnd64(), rnd64(), 1'b0, 4'hB);
    data = rnd128(); tag = 4'hC; drv_valid = 1'b1; flush = 1'b1; i_ready = 1'b0;
    step();
    flush = 1'b0; drv_valid = 1'b0;
    idle(8);

    mode = 1;
    repeat (20) send(rnd128(), rnd64(), rnd64(), ($urandom_range(0, 3) == 0), 4'($urandom));
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    mode = 0;
    idle(3);

    mode = 1;
    repeat (10000) begin
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
      send(rnd128(), rnd64(), rnd64(), ($urandom_range(0, 3) == 0), 4'($urandom));
    end

    mode = 0;
    idle(20);
    end_req = 1'b1;
    for (int w = 0; w < 10 && !end_ack; w++) step();
    if (!end_ack) begin
      $display("FAIL end_handshake: monitor did not acknowledge drain check");
      $fatal(1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
